dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial DAC driver that takes 8-bit samples from the upstream sine/waveform generator and shifts each one out as a 16-bit SPI-style frame to an external serial DAC (TLC5615-class: MSB first, sampled on SCLK rising edge, latched on CS_n rising). It sits directly downstream of the sample generator. `din_ready` doubles as that generator's advance enable, so one sample is produced per DAC frame.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range ≥1.
- `FRAME_W`, default 16: total bits per frame.
- `PAD_HI`, default 4: zero bits sent before data. Trailing zeros = `FRAME_W-PAD_HI-8`, which must be ≥0.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, 8: unsigned sample.
- `din_valid`, in, 1: sample present.
- `din_ready`, out, 1: block can accept a sample.
- `dac_cs_n`, out, 1: DAC chip select, active low.
- `dac_sclk`, out, 1: serial clock.
- `dac_din`, out, 1: serial data.
- `busy`, out, 1: transaction in progress (`= ~din_ready`).
- `done`, out, 1: one-cycle pulse when a frame is latched.

## Operation
- Frame = {`PAD_HI` zeros, `din[7:0]`, trailing zeros}, sent MSB first. Defaults: 0000_dddddddd_0000.
- FSM states IDLE, SHIFT, END, GAP. All outputs except `din_ready`/`busy` are registered.
- IDLE:
  - `din_ready`=1, `cs_n`=1, `sclk`=0.
  - On `din_valid`&`din_ready` at a rising edge (the accept edge): load the shift register with the frame, go to SHIFT, set `cs_n`=0 and `dac_din`=frame MSB, clear bit and divider counters.
  - `din` is captured only at accept; later changes are ignored.
- SHIFT:
  - Each bit occupies 2·`CLK_DIV` cycles: `sclk`=0 for `CLK_DIV` cycles, then `sclk`=1 for `CLK_DIV` cycles.
  - At the end of each bit, `sclk` returns to 0. On that same edge, `dac_din` advances to the next bit, so data is stable ≥`CLK_DIV` cycles around each rising edge.
  - After bit `FRAME_W`-1's high phase: `sclk`→0, `dac_din`→0, go to END.
- END: hold `cs_n`=0, `sclk`=0 for `CLK_DIV` cycles. Then `cs_n`→1 with `done`=1 for exactly that one cycle, and go to GAP.
- GAP: `cs_n`=1 for `CLK_DIV` cycles (DAC CS high minimum), then IDLE.
- `din_valid` outside IDLE is ignored; nothing is queued.
- Exactly `FRAME_W` rising `sclk` edges occur per frame, all while `cs_n`=0. `sclk` never toggles while `cs_n`=1.

## Timing
- Reset values (while `rst_n`=0): state IDLE, `dac_cs_n`=1, `dac_sclk`=0, `dac_din`=0, `done`=0, `din_ready`=1, `busy`=0. Counters are 0.
- Accept edge = edge 0:
  - `cs_n` falls at edge 0.
  - First `sclk` rise at edge `CLK_DIV`.
  - k-th rise (k=0..`FRAME_W`-1) at edge `CLK_DIV`·(2k+1).
  - Last `sclk` fall at edge 2·`CLK_DIV`·`FRAME_W`.
  - `cs_n` rises and `done` asserts at edge 2·`CLK_DIV`·`FRAME_W`+`CLK_DIV`.
  - `din_ready` returns at edge 2·`CLK_DIV`·`FRAME_W`+2·`CLK_DIV`.
- Defaults: `cs_n` low edges 0–132, `done` at edge 132, `din_ready` at edge 136. Sample period is 136 cycles when `din_valid` is held high.
- `din_valid` held high: the next accept occurs on the same edge `din_ready` is first sampled 1. No idle cycle beyond GAP.
- Reset mid-frame: abort immediately (asynchronously). `cs_n`→1, `sclk`→0, no `done`, frame lost. After release, `din_ready`=1 in IDLE.
- `CLK_DIV`=1: `sclk` = `clk`/2. Same sequencing, END and GAP last one cycle each.

## Test plan
- Reset check: `rst_n`=0 → outputs match the reset values above. Release with `din_valid`=0 → outputs unchanged for 50 cycles.
- Single frame, defaults: `din`=8'hA5, `din_valid` pulsed at edge 0. Sampling `dac_din` on the 16 `sclk` rises must give 0000_1010_0101_0000. `cs_n` low edges 0–132, `done` at edge 132 only, `din_ready` at 136.
- Streaming: `din_valid` held 1, `din` = 8'h00 then 8'hFF. Accepts at edges 0 and 136. Frames 0x0000 and 0x0FF0, two `done` pulses exactly 136 cycles apart.
- Ignored input: `din_valid` pulsed with 8'h3C at edge 40 during a frame carrying 8'h81. Result is exactly one frame with 0x0810, and no second frame.
- Reset mid-frame: assert `rst_n`=0 at edge 70 of a frame. `cs_n`=1 and `sclk`=0 immediately, no `done`. The next frame (8'h5A) is correct: 0x05A0.
- `CLK_DIV`=1 build: `din`=8'hC3 gives 16 `sclk` rises at odd edges 1–31, data 0x0C30, `done` at edge 33, `din_ready` at 34.

Source files
------------

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: shifts 8-bit samples out as zero-padded serial frames to a
// TLC5615-class DAC (MSB first, data sampled on sclk rise, latched on cs_n rise).
module dac_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int FRAME_W = 16,
  parameter int PAD_HI  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       done
);

  localparam int TRAIL = FRAME_W - PAD_HI - 8;
  localparam int DIV_W = $clog2(2*CLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BIT_END   = DIV_W'(2*CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END, S_GAP} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div_cnt, div_nx;
  logic [BIT_W-1:0]   bit_cnt, bit_nx;
  logic [FRAME_W-1:0] shreg, shreg_nx;
  logic [FRAME_W-1:0] frame;
  logic               cs_nx, sclk_nx, dout_nx, done_nx;
  logic               accept;

  assign frame = FRAME_W'(din) << TRAIL;

  // Ready also in the final GAP cycle so a held din_valid restarts with no idle cycle.
  assign din_ready = (state == S_IDLE) || ((state == S_GAP) && (div_cnt == HALF_LAST));
  assign busy      = ~din_ready;
  assign accept    = din_valid & din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      dac_cs_n <= 1'b1;
      dac_sclk <= 1'b0;
      dac_din  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      div_cnt  <= div_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      dac_cs_n <= cs_nx;
      dac_sclk <= sclk_nx;
      dac_din  <= dout_nx;
      done     <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    cs_nx    = dac_cs_n;
    sclk_nx  = dac_sclk;
    dout_nx  = dac_din;
    done_nx  = 1'b0;

    unique case (state)
      S_IDLE: begin
        div_nx = '0;
      end
      S_SHIFT: begin
        div_nx = div_cnt + 1'b1;
        if (div_cnt == HALF_LAST) sclk_nx = 1'b1;
        // Falling sclk and the next data bit share an edge, centring data on the rise.
        if (div_cnt == BIT_END) begin
          sclk_nx = 1'b0;
          div_nx  = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nx = S_END;
            dout_nx  = 1'b0;
          end else begin
            bit_nx   = bit_cnt + 1'b1;
            dout_nx  = shreg[FRAME_W-1];
            shreg_nx = shreg << 1;
          end
        end
      end
      S_END: begin
        div_nx = div_cnt + 1'b1;
        if (div_cnt == HALF_LAST) begin
          cs_nx    = 1'b1;
          done_nx  = 1'b1;
          div_nx   = '0;
          state_nx = S_GAP;
        end
      end
      S_GAP: begin
        div_nx = div_cnt + 1'b1;
        if (div_cnt == HALF_LAST) begin
          div_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (accept) begin
      state_nx = S_SHIFT;
      shreg_nx = frame << 1;
      dout_nx  = frame[FRAME_W-1];
      cs_nx    = 1'b0;
      sclk_nx  = 1'b0;
      div_nx   = '0;
      bit_nx   = '0;
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: checks default and CLK_DIV=1 builds of dac_spi_tx against
// frame words and edge timings computed from the serial frame rules.
module tb_dac_spi_tx;

  localparam int FW    = 16;
  localparam int PAD   = 4;
  localparam int TRAIL = FW - PAD - 8;
  localparam int CD0   = 4;
  localparam int CD1   = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din0, din1;
  logic       v0, v1;
  logic       rdy0, cs0, sclk0, dd0, busy0, done0;
  logic       rdy1, cs1, sclk1, dd1, busy1, done1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  dac_spi_tx #(.CLK_DIV(CD0), .FRAME_W(FW), .PAD_HI(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .din(din0), .din_valid(v0), .din_ready(rdy0),
    .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_din(dd0), .busy(busy0), .done(done0)
  );

  dac_spi_tx #(.CLK_DIV(CD1), .FRAME_W(FW), .PAD_HI(PAD)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .din_ready(rdy1),
    .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_din(dd1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event logs: registered outputs seen at the negedge after edge n are logged as n;
  // din_ready seen then is what edge n+1 samples.
  int   m0_csfall[$], m0_csrise[$], m0_rise[$], m0_done[$], m0_ready[$];
  logic m0_bits[$];
  int   m0_bad = 0;
  logic p0_cs = 1'b1, p0_sclk = 1'b0, p0_rdy = 1'b1;

  int   m1_csfall[$], m1_rise[$], m1_done[$], m1_ready[$];
  logic m1_bits[$];
  int   m1_bad = 0;
  logic p1_cs = 1'b1, p1_sclk = 1'b0, p1_rdy = 1'b1;

  always @(negedge clk) begin
    if (p0_cs === 1'b1 && cs0 === 1'b0) m0_csfall.push_back(cyc);
    if (p0_cs === 1'b0 && cs0 === 1'b1) m0_csrise.push_back(cyc);
    if (p0_sclk === 1'b0 && sclk0 === 1'b1) begin
      m0_rise.push_back(cyc);
      m0_bits.push_back(dd0);
    end
    if (done0 === 1'b1) m0_done.push_back(cyc);
    if (p0_rdy === 1'b0 && rdy0 === 1'b1) m0_ready.push_back(cyc + 1);
    if (cs0 === 1'b1 && sclk0 !== 1'b0) m0_bad++;
    p0_cs = cs0; p0_sclk = sclk0; p0_rdy = rdy0;

    if (p1_cs === 1'b1 && cs1 === 1'b0) m1_csfall.push_back(cyc);
    if (p1_sclk === 1'b0 && sclk1 === 1'b1) begin
      m1_rise.push_back(cyc);
      m1_bits.push_back(dd1);
    end
    if (done1 === 1'b1) m1_done.push_back(cyc);
    if (p1_rdy === 1'b0 && rdy1 === 1'b1) m1_ready.push_back(cyc + 1);
    if (cs1 === 1'b1 && sclk1 !== 1'b0) m1_bad++;
    p1_cs = cs1; p1_sclk = sclk1; p1_rdy = rdy1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] model_word(input logic [7:0] d);
    logic [15:0] w;
    w = 16'(d);
    return w << TRAIL;
  endfunction

  function automatic logic [15:0] get_word(input logic q[$], input int idx);
    logic [15:0] w;
    w = 'x;
    if (q.size() >= (idx + 1) * FW)
      for (int i = 0; i < FW; i++) w[FW-1-i] = q[idx*FW + i];
    return w;
  endfunction

  function automatic int elem(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic clear_mon();
    m0_csfall.delete(); m0_csrise.delete(); m0_rise.delete(); m0_done.delete();
    m0_ready.delete(); m0_bits.delete(); m0_bad = 0;
    m1_csfall.delete(); m1_rise.delete(); m1_done.delete();
    m1_ready.delete(); m1_bits.delete(); m1_bad = 0;
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic send0(input logic [7:0] d, output int a);
    a = cyc + 1;
    din0 = d; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, output int a);
    a = cyc + 1;
    din1 = d; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic test_reset();
    int chg;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs0 !== 1'b1)   begin errors++; $display("[TB] FAIL reset_cs_n got=%b want=1", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk got=%b want=0", sclk0); end
    checks++; if (dd0 !== 1'b0)   begin errors++; $display("[TB] FAIL reset_din got=%b want=0", dd0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done0); end
    checks++; if (rdy0 !== 1'b1)  begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", rdy0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy0); end
    checks++; if (cs1 !== 1'b1 || rdy1 !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_div1 got=%b%b want=11", cs1, rdy1); end
    rst_n = 1'b1;
    clear_mon();
    chg = 0;
    repeat (50) begin
      @(negedge clk);
      if ({cs0, sclk0, dd0, done0, rdy0, busy0} !== 6'b100010) chg++;
      if ({cs1, sclk1, dd1, done1, rdy1, busy1} !== 6'b100010) chg++;
    end
    checks++; if (chg !== 0) begin errors++; $display("[TB] FAIL idle_hold got=%0d want=0", chg); end
    checks++; if (m0_csfall.size() != 0 || m0_rise.size() != 0)
      begin errors++; $display("[TB] FAIL idle_activity got=%0d want=0", m0_csfall.size() + m0_rise.size()); end
  endtask

  task automatic test_single();
    int a, bad;
    clear_mon();
    send0(8'hA5, a);
    while (cyc < a + 150) @(negedge clk);
    checks++; if (elem(m0_csfall, 0) != a || m0_csfall.size() != 1)
      begin errors++; $display("[TB] FAIL single_cs_fall got=%0d want=%0d", elem(m0_csfall, 0) - a, 0); end
    checks++; if (m0_rise.size() != FW)
      begin errors++; $display("[TB] FAIL single_rises got=%0d want=%0d", m0_rise.size(), FW); end
    bad = 0;
    for (int k = 0; k < FW; k++) if (elem(m0_rise, k) != a + CD0*(2*k + 1)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL single_rise_time got=%0d want=0 late", bad); end
    checks++; if (get_word(m0_bits, 0) !== 16'h0A50)
      begin errors++; $display("[TB] FAIL single_word got=%h want=0a50", get_word(m0_bits, 0)); end
    checks++; if (elem(m0_csrise, 0) != a + 132)
      begin errors++; $display("[TB] FAIL single_cs_rise got=%0d want=132", elem(m0_csrise, 0) - a); end
    checks++; if (elem(m0_done, 0) != a + 132 || m0_done.size() != 1)
      begin errors++; $display("[TB] FAIL single_done got=%0d n=%0d want=132 n=1", elem(m0_done, 0) - a, m0_done.size()); end
    checks++; if (elem(m0_ready, 0) != a + 136)
      begin errors++; $display("[TB] FAIL single_ready got=%0d want=136", elem(m0_ready, 0) - a); end
    checks++; if (m0_bad !== 0) begin errors++; $display("[TB] FAIL single_sclk_cs got=%0d want=0", m0_bad); end
  endtask

  task automatic test_back_to_back();
    int a;
    clear_mon();
    a = cyc + 1;
    din0 = 8'h00; v0 = 1'b1;
    @(negedge clk);
    din0 = 8'hFF;
    while (cyc < a + 136) @(negedge clk);
    v0 = 1'b0;
    while (cyc < a + 300) @(negedge clk);
    checks++; if (m0_csfall.size() != 2 || elem(m0_csfall, 0) != a || elem(m0_csfall, 1) != a + 136)
      begin errors++; $display("[TB] FAIL stream_accepts got=%0d,%0d want=0,136", elem(m0_csfall, 0) - a, elem(m0_csfall, 1) - a); end
    checks++; if (get_word(m0_bits, 0) !== 16'h0000)
      begin errors++; $display("[TB] FAIL stream_word0 got=%h want=0000", get_word(m0_bits, 0)); end
    checks++; if (get_word(m0_bits, 1) !== 16'h0FF0)
      begin errors++; $display("[TB] FAIL stream_word1 got=%h want=0ff0", get_word(m0_bits, 1)); end
    checks++; if (m0_done.size() != 2 || elem(m0_done, 0) != a + 132)
      begin errors++; $display("[TB] FAIL stream_done got=%0d n=%0d want=132 n=2", elem(m0_done, 0) - a, m0_done.size()); end
    checks++; if (elem(m0_done, 1) - elem(m0_done, 0) != 136)
      begin errors++; $display("[TB] FAIL stream_period got=%0d want=136", elem(m0_done, 1) - elem(m0_done, 0)); end
    checks++; if (m0_rise.size() != 2*FW)
      begin errors++; $display("[TB] FAIL stream_rises got=%0d want=%0d", m0_rise.size(), 2*FW); end
  endtask

  task automatic test_ignored();
    int a;
    clear_mon();
    send0(8'h81, a);
    while (cyc < a + 39) @(negedge clk);
    din0 = 8'h3C; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    while (cyc < a + 300) @(negedge clk);
    checks++; if (m0_csfall.size() != 1)
      begin errors++; $display("[TB] FAIL ignored_frames got=%0d want=1", m0_csfall.size()); end
    checks++; if (get_word(m0_bits, 0) !== 16'h0810)
      begin errors++; $display("[TB] FAIL ignored_word got=%h want=0810", get_word(m0_bits, 0)); end
    checks++; if (m0_done.size() != 1 || elem(m0_done, 0) != a + 132)
      begin errors++; $display("[TB] FAIL ignored_done got=%0d n=%0d want=132 n=1", elem(m0_done, 0) - a, m0_done.size()); end
  endtask

  task automatic test_reset_mid();
    int a, b;
    clear_mon();
    send0(8'($urandom), a);
    while (cyc < a + 69) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cs0 !== 1'b1)   begin errors++; $display("[TB] FAIL abort_cs_n got=%b want=1", cs0); end
    checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_sclk got=%b want=0", sclk0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got=%b want=0", done0); end
    checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0)
      begin errors++; $display("[TB] FAIL abort_ready got=%b%b want=10", rdy0, busy0); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    while (cyc < a + 150) @(negedge clk);
    checks++; if (m0_done.size() != 0)
      begin errors++; $display("[TB] FAIL abort_no_done got=%0d want=0", m0_done.size()); end
    checks++; if (m0_csfall.size() != 1)
      begin errors++; $display("[TB] FAIL abort_no_restart got=%0d want=1", m0_csfall.size()); end
    clear_mon();
    send0(8'h5A, b);
    while (cyc < b + 150) @(negedge clk);
    checks++; if (get_word(m0_bits, 0) !== 16'h05A0)
      begin errors++; $display("[TB] FAIL after_abort_word got=%h want=05a0", get_word(m0_bits, 0)); end
    checks++; if (elem(m0_done, 0) != b + 132 || elem(m0_ready, 0) != b + 136)
      begin errors++; $display("[TB] FAIL after_abort_timing got=%0d,%0d want=132,136", elem(m0_done, 0) - b, elem(m0_ready, 0) - b); end
  endtask

  task automatic test_clkdiv1();
    int a, bad;
    clear_mon();
    send1(8'hC3, a);
    while (cyc < a + 60) @(negedge clk);
    checks++; if (elem(m1_csfall, 0) != a)
      begin errors++; $display("[TB] FAIL div1_cs_fall got=%0d want=0", elem(m1_csfall, 0) - a); end
    checks++; if (m1_rise.size() != FW)
      begin errors++; $display("[TB] FAIL div1_rises got=%0d want=%0d", m1_rise.size(), FW); end
    bad = 0;
    for (int k = 0; k < FW; k++) if (elem(m1_rise, k) != a + 2*k + 1) bad++;
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL div1_rise_time got=%0d want=0 late", bad); end
    checks++; if (get_word(m1_bits, 0) !== 16'h0C30)
      begin errors++; $display("[TB] FAIL div1_word got=%h want=0c30", get_word(m1_bits, 0)); end
    checks++; if (elem(m1_done, 0) != a + 33 || m1_done.size() != 1)
      begin errors++; $display("[TB] FAIL div1_done got=%0d want=33", elem(m1_done, 0) - a); end
    checks++; if (elem(m1_ready, 0) != a + 34)
      begin errors++; $display("[TB] FAIL div1_ready got=%0d want=34", elem(m1_ready, 0) - a); end
    checks++; if (m1_bad !== 0) begin errors++; $display("[TB] FAIL div1_sclk_cs got=%0d want=0", m1_bad); end
  endtask

  task automatic test_random();
    int          exp_a[$];
    logic [15:0] exp_w[$];
    int          t, a, gap, off;
    logic [7:0]  d;
    clear_mon();
    t = cyc;
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 12);
      while (cyc < t + gap) @(negedge clk);
      send0(d, a);
      din0 = 8'($urandom);
      exp_a.push_back(a);
      exp_w.push_back(model_word(d));
      off = $urandom_range(2, 120);
      while (cyc < a + off) @(negedge clk);
      din0 = 8'($urandom); v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      // Earliest accept is the edge 2*CD*FW + 2*CD after the previous one.
      t = a + 2*CD0*FW + 2*CD0 - 1;
    end
    while (cyc < t + 20) @(negedge clk);
    checks++; if (m0_csfall.size() != 6)
      begin errors++; $display("[TB] FAIL rand_frames got=%0d want=6", m0_csfall.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (elem(m0_csfall, i) != exp_a[i])
        begin errors++; $display("[TB] FAIL rand_accept%0d got=%0d want=%0d", i, elem(m0_csfall, i), exp_a[i]); end
      checks++; if (get_word(m0_bits, i) !== exp_w[i])
        begin errors++; $display("[TB] FAIL rand_word%0d got=%h want=%h", i, get_word(m0_bits, i), exp_w[i]); end
      checks++; if (elem(m0_done, i) != exp_a[i] + 2*CD0*FW + CD0)
        begin errors++; $display("[TB] FAIL rand_done%0d got=%0d want=%0d", i, elem(m0_done, i), exp_a[i] + 2*CD0*FW + CD0); end
    end
    checks++; if (m0_bad !== 0 || m0_rise.size() != 6*FW)
      begin errors++; $display("[TB] FAIL rand_sclk got=%0d/%0d want=0/%0d", m0_bad, m0_rise.size(), 6*FW); end
  endtask

  initial begin
    din0 = '0; v0 = 1'b0;
    din1 = '0; v1 = 1'b0;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_clkdiv1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
